// File: rtl/tortoise_pkg.sv
// tortoise_pkg: shared core types for the tortoise frontend (fetch entries, exceptions, predictions)
package tortoise_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned FETCH_QUEUE_DEPTH = 4;

    typedef enum logic [4:0] {
        INSTR_ADDR_MISALIGNED = 5'd0,
        INSTR_ACCESS_FAULT    = 5'd1,
        ILLEGAL_INSTR         = 5'd2,
        BREAKPOINT            = 5'd3,
        INSTR_PAGE_FAULT      = 5'd12
    } exc_cause_e;

    typedef struct packed {
        logic            valid;
        exc_cause_e      cause;
        logic [XLEN-1:0] tval;
    } exception_t;

    typedef struct packed {
        logic            valid;
        logic            taken;
        logic [XLEN-1:0] target;
    } branch_predict_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] addr;
        logic [31:0]     instr;
        branch_predict_t predict;
        exception_t      ex;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: fetch-to-decode entry queue with flush and exception stall; FETCH_QUEUE_BYPASS_EN enables zero-latency bypass when empty
module fetch_queue
    import tortoise_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   fetch_valid_i,
    input  fetch_entry_t           fetch_entry_i,
    output logic                   fetch_ready_o,
    output fetch_entry_t           fetch_o,
    input  logic                   decode_ack_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ex_pending_q, ex_pending_d;
    logic             empty, accept, enq, deq;

    assign empty         = count_q == '0;
    assign fetch_ready_o = (count_q != FULL) && !ex_pending_q && !flush_i;
    assign accept        = fetch_valid_i && fetch_ready_o;
    assign count_o       = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass = empty && !flush_i;
    // An empty queue forwards the frontend entry straight to decode; a same-cycle ack consumes it without storing it.
    always_comb begin
        fetch_o       = bypass ? fetch_entry_i : mem_q[rd_ptr_q];
        fetch_o.valid = bypass ? accept : (!empty && !flush_i);
    end
    assign enq = accept && !(bypass && decode_ack_i);
    assign deq = !bypass && fetch_o.valid && decode_ack_i;
`else
    // Head entry goes to decode; its valid bit is rebuilt from occupancy and masked by flush.
    always_comb begin
        fetch_o       = mem_q[rd_ptr_q];
        fetch_o.valid = !empty && !flush_i;
    end
    assign enq = accept;
    assign deq = fetch_o.valid && decode_ack_i;
`endif

    // Next-state: pointers and count follow enq/deq; a flush zeroes everything; a faulting entry latches the stall.
    always_comb begin
        rd_ptr_d     = flush_i ? '0 : rd_ptr_q + PTR_W'(deq);
        wr_ptr_d     = flush_i ? '0 : wr_ptr_q + PTR_W'(enq);
        count_d      = flush_i ? '0 : count_q + (PTR_W + 1)'(enq) - (PTR_W + 1)'(deq);
        ex_pending_d = !flush_i && (ex_pending_q || (accept && fetch_entry_i.ex.valid));
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            ex_pending_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            ex_pending_q <= ex_pending_d;
        end
    end

    // Entry storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q] <= fetch_entry_i;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized self-checking bench for fetch_queue against a queue-based reference model
module tb_fetch_queue;
    import tortoise_pkg::*;

    localparam int DEPTH = 4;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         flush_i = 1'b0;
    logic         fetch_valid_i = 1'b0;
    fetch_entry_t fetch_entry_i = '0;
    logic         fetch_ready_o;
    fetch_entry_t fetch_o;
    logic         decode_ack_i = 1'b0;
    logic [2:0]   count_o;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .fetch_valid_i(fetch_valid_i), .fetch_entry_i(fetch_entry_i),
        .fetch_ready_o(fetch_ready_o), .fetch_o(fetch_o),
        .decode_ack_i(decode_ack_i), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass = 0;

    fetch_entry_t mq[$];
    bit           m_ex;
    bit           exp_valid, exp_ready;
    int           exp_count;
    fetch_entry_t exp_entry;
    bit           m_enq, m_deq, m_setex, m_fl;
    fetch_entry_t m_e;

    function automatic fetch_entry_t mk(logic [31:0] a);
        fetch_entry_t e;
        e = '0;
        e.valid = $urandom;
        e.addr = a;
        e.instr = $urandom;
        e.predict.valid = $urandom;
        e.predict.taken = $urandom;
        e.predict.target = $urandom;
        return e;
    endfunction

    function automatic bit same(fetch_entry_t a, fetch_entry_t b);
        return a.addr === b.addr && a.instr === b.instr && a.predict === b.predict && a.ex === b.ex;
    endfunction

    task automatic apply(bit fv, fetch_entry_t e, bit ack, bit fl);
        bit bypass;
        fetch_valid_i = fv; fetch_entry_i = e; decode_ack_i = ack; flush_i = fl;
        #1;
        bypass = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass = mq.size() == 0 && !fl;
`endif
        exp_count = mq.size();
        exp_ready = mq.size() < DEPTH && !m_ex && !fl;
        exp_valid = bypass ? (fv && exp_ready) : (mq.size() != 0 && !fl);
        exp_entry = (bypass || mq.size() == 0) ? e : mq[0];
        m_enq = fv && exp_ready && !(bypass && ack);
        m_deq = exp_valid && ack && !bypass;
        m_setex = fv && exp_ready && e.ex.valid;
        m_fl = fl; m_e = e;
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (m_fl) begin
            mq.delete(); m_ex = 0;
        end else begin
            if (m_deq) void'(mq.pop_front());
            if (m_enq) mq.push_back(m_e);
            if (m_setex) m_ex = 1;
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 0;
        repeat (2) @(negedge clk_i);
        n_checks++; if (fetch_o.valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", fetch_o.valid); else n_pass++;
        n_checks++; if (count_o !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count_o); else n_pass++;
        n_checks++; if (fetch_ready_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", fetch_ready_o); else n_pass++;
        rst_ni = 1;
        mq.delete(); m_ex = 0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            apply(1, mk(32'h8000_0000 + 32'(4 * i)), 0, 0);
            tick();
        end
        apply(0, mk(32'h0), 0, 0);
        n_checks++; if (count_o !== 3'd4) $display("FAIL fill_count got=%0d exp=4", count_o); else n_pass++;
        n_checks++; if (fetch_ready_o !== 1'b0) $display("FAIL fill_ready got=%b exp=0", fetch_ready_o); else n_pass++;
        n_checks++; if (fetch_o.valid !== 1'b1 || fetch_o.addr !== 32'h8000_0000) $display("FAIL fill_head got=%b/%h exp=1/80000000", fetch_o.valid, fetch_o.addr); else n_pass++;
    endtask

    task automatic test_full_ack();
        apply(1, mk(32'h8000_0010), 1, 0);
        n_checks++; if (fetch_ready_o !== 1'b0) $display("FAIL full_ack_ready got=%b exp=0", fetch_ready_o); else n_pass++;
        tick();
        apply(0, mk(32'h0), 0, 0);
        n_checks++; if (count_o !== 3'd3) $display("FAIL full_ack_count got=%0d exp=3", count_o); else n_pass++;
        n_checks++; if (fetch_o.addr !== 32'h8000_0004) $display("FAIL full_ack_head got=%h exp=80000004", fetch_o.addr); else n_pass++;
        apply(0, mk(32'h0), 0, 1);
        tick();
    endtask

    task automatic test_wrap();
        fetch_entry_t sent[$];
        fetch_entry_t got[$];
        int idx = 0;
        for (int i = 0; i < 10; i++) sent.push_back(mk(32'h8000_1000 + 32'(4 * i)));
        for (int c = 0; c < 40 && !(idx == 10 && mq.size() == 0); c++) begin
            apply(idx < 10, sent[idx < 10 ? idx : 9], 1, 0);
            n_checks++; if (fetch_o.valid !== exp_valid) $display("FAIL wrap_valid got=%b exp=%b", fetch_o.valid, exp_valid); else n_pass++;
            if (fetch_o.valid) got.push_back(fetch_o);
            if (m_enq) idx++;
            tick();
        end
        n_checks++; if (got.size() != 10) $display("FAIL wrap_delivered got=%0d exp=10", got.size()); else n_pass++;
        for (int i = 0; i < got.size() && i < 10; i++) begin
            n_checks++; if (!same(got[i], sent[i])) $display("FAIL wrap_order[%0d] got=%h/%h exp=%h/%h", i, got[i].addr, got[i].instr, sent[i].addr, sent[i].instr); else n_pass++;
        end
    endtask

    task automatic test_exception();
        fetch_entry_t e;
        e = mk(32'h8000_2000);
        e.ex.valid = 1; e.ex.cause = ILLEGAL_INSTR; e.ex.tval = 32'hdead_beef;
        apply(1, e, 0, 0);
        n_checks++; if (fetch_ready_o !== 1'b1) $display("FAIL ex_ready_before got=%b exp=1", fetch_ready_o); else n_pass++;
        tick();
        apply(1, mk(32'h8000_2004), 0, 0);
        n_checks++; if (fetch_ready_o !== 1'b0) $display("FAIL ex_ready_after got=%b exp=0", fetch_ready_o); else n_pass++;
        apply(1, mk(32'h8000_2004), 1, 0);
        n_checks++; if (fetch_o.valid !== 1'b1 || !same(fetch_o, e)) $display("FAIL ex_drain got=%b/%b/%0d/%h exp=1/1/2/deadbeef", fetch_o.valid, fetch_o.ex.valid, fetch_o.ex.cause, fetch_o.ex.tval); else n_pass++;
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(1, mk(32'h8000_2008), 0, 0);
            n_checks++; if (fetch_ready_o !== 1'b0 || count_o !== 3'd0) $display("FAIL ex_stall got=%b/%0d exp=0/0", fetch_ready_o, count_o); else n_pass++;
            tick();
        end
        apply(1, mk(32'h8000_200c), 0, 1);
        tick();
        apply(0, mk(32'h0), 0, 0);
        n_checks++; if (fetch_ready_o !== 1'b1) $display("FAIL ex_after_flush_ready got=%b exp=1", fetch_ready_o); else n_pass++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            apply(1, mk(32'h8000_3000 + 32'(4 * i)), 0, 0);
            tick();
        end
        apply(1, mk(32'h8000_300c), 1, 1);
        n_checks++; if (fetch_o.valid !== 1'b0 || fetch_ready_o !== 1'b0) $display("FAIL flush_mask got=%b/%b exp=0/0", fetch_o.valid, fetch_ready_o); else n_pass++;
        n_checks++; if (count_o !== 3'd3) $display("FAIL flush_count_now got=%0d exp=3", count_o); else n_pass++;
        tick();
        apply(1, mk(32'h8000_3010), 0, 1);
        n_checks++; if (count_o !== 3'd0) $display("FAIL flush_count_next got=%0d exp=0", count_o); else n_pass++;
        tick();
        apply(0, mk(32'h0), 0, 0);
        n_checks++; if (count_o !== 3'd0 || fetch_o.valid !== 1'b0) $display("FAIL flush_b2b got=%0d/%b exp=0/0", count_o, fetch_o.valid); else n_pass++;
    endtask

    task automatic test_latency();
        fetch_entry_t e;
        e = mk(32'h9000_0000);
        apply(1, e, 1, 0);
`ifdef FETCH_QUEUE_BYPASS_EN
        n_checks++; if (fetch_o.valid !== 1'b1 || fetch_o.addr !== e.addr) $display("FAIL bypass_fwd got=%b/%h exp=1/%h", fetch_o.valid, fetch_o.addr, e.addr); else n_pass++;
        tick();
        apply(0, mk(32'h0), 0, 0);
        n_checks++; if (count_o !== 3'd0) $display("FAIL bypass_count got=%0d exp=0", count_o); else n_pass++;
`else
        n_checks++; if (fetch_o.valid !== 1'b0) $display("FAIL nobypass_fwd got=%b exp=0", fetch_o.valid); else n_pass++;
        tick();
        apply(0, mk(32'h0), 1, 0);
        n_checks++; if (fetch_o.valid !== 1'b1 || fetch_o.addr !== e.addr) $display("FAIL nobypass_next got=%b/%h exp=1/%h", fetch_o.valid, fetch_o.addr, e.addr); else n_pass++;
        tick();
`endif
    endtask

    task automatic test_random();
        fetch_entry_t e;
        int errs = 0;
        for (int c = 0; c < 400; c++) begin
            e = mk($urandom);
            e.ex.valid = ($urandom % 25) == 0;
            e.ex.cause = INSTR_PAGE_FAULT;
            e.ex.tval = $urandom;
            apply(($urandom % 4) != 0, e, ($urandom % 3) != 0, ($urandom % 40) == 0);
            n_checks++;
            if (fetch_o.valid !== exp_valid || fetch_ready_o !== exp_ready || 32'(count_o) !== exp_count || (exp_valid && !same(fetch_o, exp_entry))) begin
                if (errs++ < 10) $display("FAIL random[%0d] got=%b/%b/%0d/%h exp=%b/%b/%0d/%h", c, fetch_o.valid, fetch_ready_o, count_o, fetch_o.addr, exp_valid, exp_ready, exp_count, exp_entry.addr);
            end else n_pass++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        apply(0, mk(32'h0), 0, 1);
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(1, mk(32'h8000_4000 + 32'(4 * i)), 0, 0);
            tick();
        end
        fetch_valid_i = 0;
        #2 rst_ni = 0;
        #1;
        n_checks++; if (count_o !== 3'd0 || fetch_o.valid !== 1'b0) $display("FAIL async_reset got=%0d/%b exp=0/0", count_o, fetch_o.valid); else n_pass++;
        @(negedge clk_i);
        rst_ni = 1;
        mq.delete(); m_ex = 0;
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_fill();
        test_full_ack();
        test_wrap();
        test_exception();
        test_flush();
        test_latency();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
